axo_regfile_sb: RTL

Parametrised integer register file: configurable width, depth and read-port count, two write ports and a per-register pending-write scoreboard.
- Port A is the early single-cycle EX writeback; port B is the late load/MUL/DIV writeback.
- The scoreboard tracks registers reserved by multi-cycle ops so the issue stage can stall on RAW hazards.
- Sits between decode/issue and the writeback stages of the pipelined core.

---
 rtl/axo_regfile_sb_pkg.sv | 27 ++
 rtl/axo_regfile_sb_scoreboard.sv | 62 ++++++
 rtl/axo_regfile_sb.sv | 87 ++++++++
 3 files changed

// File: rtl/axo_regfile_sb_pkg.sv
// axo_pkg: shared constants, address type and port-slicing helpers
// for the axo_regfile_sb register file slice.
package axo_pkg;

    localparam int AXO_NREGS_I = 32;
    localparam int AXO_NREGS_E = 16;
    localparam int AXO_AW      = 5;
    localparam int AXO_MAXRD   = 3;
    localparam int AXO_NSLOT   = 1 << AXO_AW;

    typedef logic [AXO_AW-1:0] axo_addr_t;

    function automatic axo_addr_t axo_port_addr(
        input logic [AXO_MAXRD*AXO_AW-1:0] vec,
        input int unsigned                 idx
    );
        return vec[idx*AXO_AW +: AXO_AW];
    endfunction

    function automatic logic axo_addr_ok(
        input axo_addr_t   a,
        input int unsigned nregs
    );
        return (a != '0) && (32'(a) < nregs);
    endfunction

endpackage

// File: rtl/axo_regfile_sb_scoreboard.sv
// axo_scoreboard: per-register pending-write busy bits with
// reserve/clear/flush priority, conflict pulse and busy summary.
module axo_scoreboard
    import axo_pkg::*;
#(
    parameter int NREGS = AXO_NREGS_I,
    parameter int NREAD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AXO_AW-1:0] raddr,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    wb_en,
    input  axo_addr_t               wb_addr,
    input  logic                    rsv_en,
    input  axo_addr_t               rsv_addr,
    input  logic                    flush,
    output logic                    sb_conflict,
    output logic                    busy_any
);

    logic [AXO_NSLOT-1:0]        busy_q, busy_d;
    logic                        conflict_q, conflict_d;
    logic                        wb_ok, rsv_ok;
    logic [AXO_MAXRD*AXO_AW-1:0] raddr_x;

    assign wb_ok   = wb_en && axo_addr_ok(wb_addr, NREGS);
    assign rsv_ok  = rsv_en && axo_addr_ok(rsv_addr, NREGS);
    assign raddr_x = (AXO_MAXRD*AXO_AW)'(raddr);

    // x0 and out-of-range slots are never set, so they stay 0
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_ok)  busy_d[wb_addr]  = 1'b0;
            if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        end
    end

    assign conflict_d = rsv_ok && !flush && busy_q[rsv_addr]
                     && !(wb_ok && (wb_addr == rsv_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rbusy
        assign rbusy[i] = busy_q[axo_port_addr(raddr_x, i)];
    end

    assign sb_conflict = conflict_q;
    assign busy_any    = |busy_q;

endmodule

// File: rtl/axo_regfile_sb.sv
// axo_regfile_sb: dual-write register file with pending-write scoreboard.
// Define AXO_REGFILE_BYPASS_EN for same-cycle write-through reads.
module axo_regfile_sb
    import axo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = AXO_NREGS_I,
    parameter int NREAD = 2,
    parameter int AW    = AXO_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic                  sb_conflict,
    output logic                  busy_any
);

    logic [XLEN-1:0]             mem_q [AXO_NSLOT];
    logic                        wa_ok, wb_ok;
    logic [NREAD-1:0]            sb_rbusy;
    logic [AXO_MAXRD*AXO_AW-1:0] raddr_x;

    assign wa_ok   = wa_en && axo_addr_ok(wa_addr, NREGS);
    assign wb_ok   = wb_en && axo_addr_ok(wb_addr, NREGS);
    assign raddr_x = (AXO_MAXRD*AXO_AW)'(raddr);

    // Port A is applied last: the EX result is younger than the late one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < AXO_NSLOT; r++) mem_q[r] <= '0;
        end else begin
            if (wb_ok) mem_q[wb_addr] <= wb_data;
            if (wa_ok) mem_q[wa_addr] <= wa_data;
        end
    end

    axo_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr),
        .rbusy       (sb_rbusy),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .sb_conflict (sb_conflict),
        .busy_any    (busy_any)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        axo_addr_t       a;
        logic [XLEN-1:0] val;

        assign a = axo_port_addr(raddr_x, i);

        always_comb begin
            val = axo_addr_ok(a, NREGS) ? mem_q[a] : '0;
`ifdef AXO_REGFILE_BYPASS_EN
            if (wa_ok && (wa_addr == a))      val = wa_data;
            else if (wb_ok && (wb_addr == a)) val = wb_data;
`endif
        end

        assign rdata[i*XLEN +: XLEN] = rst ? '0 : val;
`ifdef AXO_REGFILE_BYPASS_EN
        assign rbusy[i] = sb_rbusy[i] & ~(wb_ok && (wb_addr == a));
`else
        assign rbusy[i] = sb_rbusy[i];
`endif
    end

endmodule
